// File: rtl/sfp_sum_tx.sv
// sfp_sum_tx: transmit end of the inter-core row-sum exchange.
// Captures each local row sum one cycle after its accumulate strobe, queues
// the sums in order with a wrapping row tag, and offers the head entry to
// the partner core over a valid/ready link.
module sfp_sum_tx #(
  parameter int bw_sum = 24,
  parameter int depth  = 16,
  parameter int aw     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc,
  input  logic [bw_sum-1:0] sum_local,
  input  logic              clr,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [bw_sum-1:0] tx_data,
  output logic [aw-1:0]     tx_tag,
  output logic [aw:0]       count,
  output logic              full,
  output logic              overflow
);

  localparam logic [aw:0] depth_c = (aw+1)'(depth);

  logic              acc_q;
  logic [aw-1:0]     wr_ptr;
  logic [aw-1:0]     rd_ptr;
  logic [aw-1:0]     tag_cnt;
  logic [bw_sum-1:0] data_mem [depth];
  logic [aw-1:0]     tag_mem  [depth];

  logic pop;
  logic push;
  logic drop;

  // Handshake and write-acceptance decode; a pop frees a slot even when full.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path, otherwise a latch is inferred.
    pop  = tx_valid && tx_ready;
    push = acc_q && (!full || pop);
    drop = acc_q && full && !pop;
  end

  // Link outputs: head entry read straight from the flop array, zero when empty.
  always_comb begin
    tx_valid = (count != '0);
    full     = (count == depth_c);
    tx_data  = '0;
    tx_tag   = '0;
    if (tx_valid) begin
      tx_data = data_mem[rd_ptr];
      tx_tag  = tag_mem[rd_ptr];
    end
  end

  // Strobe delay: the sum is valid the cycle after acc; clr does not touch it.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!reset) acc_q <= 1'b0;
    else        acc_q <= acc;
  end

  // Queue control: pointers, occupancy, tag counter and sticky overflow; clr wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tag_cnt  <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tag_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        tag_cnt <= tag_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write: sum and its tag land at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; its contents are masked by count, so only control state is reset.
    if (push && !clr) begin
      data_mem[wr_ptr] <= sum_local;
      tag_mem[wr_ptr]  <= tag_cnt;
    end
  end

endmodule

// File: tb/tb_sfp_sum_tx.sv
// Directed testbench for sfp_sum_tx: capture latency, back-pressure, fill and
// overflow, full push/pop, tag wrap, flush and asynchronous reset.
module tb_sfp_sum_tx;

  localparam int bw_sum = 24;
  localparam int depth  = 16;
  localparam int aw     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              acc;
  logic [bw_sum-1:0] sum_local;
  logic              clr;
  logic              tx_valid;
  logic              tx_ready;
  logic [bw_sum-1:0] tx_data;
  logic [aw-1:0]     tx_tag;
  logic [aw:0]       count;
  logic              full;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;

  sfp_sum_tx #(.bw_sum(bw_sum), .depth(depth), .aw(aw)) dut (
    .clk       (clk),
    .reset     (reset),
    .acc       (acc),
    .sum_local (sum_local),
    .clr       (clr),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_tag    (tx_tag),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then changed and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One acc pulse followed by its sum in the next cycle; entry visible afterwards.
  task automatic capture(input logic [bw_sum-1:0] s);
    acc = 1'b1;
    tick();
    acc       = 1'b0;
    sum_local = s;
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    acc       = 1'b0;
    sum_local = '0;
    clr       = 1'b0;
    tx_ready  = 1'b0;

    // Reset state
    #3;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_tag", 32'(tx_tag), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single capture with latency, stall and single pop
    acc = 1'b1;
    tick();
    acc       = 1'b0;
    sum_local = 24'h000123;
    check("lat_c1_valid", 32'(tx_valid), 32'd0);
    tick();
    check("single_valid", 32'(tx_valid), 32'd1);
    check("single_data", 32'(tx_data), 32'h000123);
    check("single_tag", 32'(tx_tag), 32'd0);
    check("single_count", 32'(count), 32'd1);
    sum_local = 24'hFFFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_data", 32'(tx_data), 32'h000123);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("pop_valid", 32'(tx_valid), 32'd0);
    check("pop_count", 32'(count), 32'd0);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("ready_empty_count", 32'(count), 32'd0);

    // Fill with back-to-back acc pulses (sums 1..16), then overflow
    do_clr();
    for (int i = 0; i <= 16; i++) begin
      acc       = (i < 16);
      sum_local = 24'(i);
      tick();
    end
    acc = 1'b0;
    check("fill_count", 32'(count), 32'd16);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovf", 32'(overflow), 32'd0);
    capture(24'd17);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_set", 32'(overflow), 32'd1);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", 32'(tx_valid), 32'd1);
      check("drain_data", 32'(tx_data), 32'(i + 1));
      check("drain_tag", 32'(tx_tag), 32'(i));
      tick();
    end
    tx_ready = 1'b0;
    check("drain_empty", 32'(tx_valid), 32'd0);
    check("drain_ovf_hold", 32'(overflow), 32'd1);

    // Full with simultaneous push and pop
    do_clr();
    for (int i = 0; i < 16; i++) capture(24'(i + 1));
    check("pp_pre_full", 32'(full), 32'd1);
    acc = 1'b1;
    tick();
    acc       = 1'b0;
    sum_local = 24'hABCDEF;
    tx_ready  = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("pp_count", 32'(count), 32'd16);
    check("pp_ovf", 32'(overflow), 32'd0);
    tx_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check("pp_data", 32'(tx_data), 32'(i + 1));
      check("pp_tag", 32'(tx_tag), 32'(i));
      tick();
    end
    check("pp_new_data", 32'(tx_data), 32'hABCDEF);
    check("pp_new_tag", 32'(tx_tag), 32'd0);
    tick();
    check("pp_empty", 32'(tx_valid), 32'd0);

    // Tag wrap while streaming
    do_clr();
    for (int i = 0; i < 20; i++) begin
      capture(24'(100 + i));
      check("wrap_valid", 32'(tx_valid), 32'd1);
      check("wrap_tag", 32'(tx_tag), 32'(i % 16));
      check("wrap_data", 32'(tx_data), 32'(100 + i));
    end
    tick();
    tx_ready = 1'b0;
    check("wrap_empty", 32'(count), 32'd0);

    // Flush with 5 pending entries and overflow set, coincident with a capture
    do_clr();
    for (int i = 0; i < 17; i++) capture(24'(i));
    tx_ready = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    tx_ready = 1'b0;
    check("pre_clr_count", 32'(count), 32'd5);
    check("pre_clr_ovf", 32'(overflow), 32'd1);
    acc = 1'b1;
    tick();
    acc       = 1'b0;
    sum_local = 24'h000777;
    clr       = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_valid", 32'(tx_valid), 32'd0);
    check("clr_count", 32'(count), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_data", 32'(tx_data), 32'd0);
    capture(24'h000055);
    check("post_clr_tag", 32'(tx_tag), 32'd0);
    check("post_clr_data", 32'(tx_data), 32'h000055);
    // acc during clr survives into the next cycle
    acc = 1'b1;
    clr = 1'b1;
    tick();
    acc       = 1'b0;
    clr       = 1'b0;
    sum_local = 24'h000099;
    tick();
    check("clr_acc_count", 32'(count), 32'd1);
    check("clr_acc_data", 32'(tx_data), 32'h000099);
    check("clr_acc_tag", 32'(tx_tag), 32'd0);

    // Asynchronous reset mid-cycle with entries pending
    do_clr();
    for (int i = 0; i < 3; i++) capture(24'(i + 7));
    check("pre_rst_count", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(tx_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    capture(24'h000321);
    check("post_rst_tag", 32'(tx_tag), 32'd0);
    check("post_rst_data", 32'(tx_data), 32'h000321);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/sfp_sum_tx.md
Name: sfp_sum_tx

Overview:
- Transmit end of the inter-core row-sum exchange used by softmax normalization.
- Captures each per-row absolute-value sum that the local special-function row produces after an accumulate command.
- Buffers up to `depth` sums in order and sends them to the partner core over a valid/ready link with a wrapping row tag.
- The partner's receive path feeds those sums into its external-sum input ahead of its divide phase.

Parameters:
- bw_sum, 24, width of one row sum (matches the 2*bw+8 sum width of the row datapath)
- depth, 16, entries of sum storage (power of two)
- aw, 4, log2(depth); width of pointers and row tag

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- acc  input  1  accumulate strobe, same pulse that drives the local row's acc
- sum_local  input  bw_sum  local row sum; valid in the cycle after acc
- clr  input  1  synchronous flush, active-high
- tx_valid  output  1  head entry available on the link
- tx_ready  input  1  partner accepts when high together with tx_valid
- tx_data  output  bw_sum  head row sum
- tx_tag  output  aw  row sequence number of the head entry
- count  output  aw+1  number of stored entries
- full  output  1  count == depth
- overflow  output  1  sticky: a capture was dropped

Behaviour:
- Reset (reset low, asynchronous):
  - Pointers, count and tag counter go to 0; overflow goes to 0.
  - acc_q (registered copy of acc) goes to 0.
  - Outputs during and after reset: tx_valid=0, full=0, count=0, tx_tag=0, tx_data=0.
  - Storage contents are don't-care.
- Capture:
  - acc_q registers acc every cycle.
  - When acc_q=1, sum_local and the current tag counter form one write request.
  - The tag counter increments by 1 per accepted write and wraps from depth-1 to 0.
- Latency: acc high in cycle t; sum_local sampled at the end of cycle t+1; tx_valid high in cycle t+2 if storage was empty.
- Link:
  - tx_valid = (count != 0).
  - tx_data and tx_tag come from the entry at the read pointer, via combinational read of the flop array.
  - A pop occurs when tx_valid && tx_ready.
  - While tx_valid && !tx_ready, tx_data and tx_tag stay stable.
  - tx_valid never deasserts without a pop, clr or reset.
  - tx_ready with tx_valid=0 has no effect.
- Write acceptance:
  - A write is accepted when (!full || pop).
  - Push and pop in the same cycle leave count unchanged; the order stays intact even when full.
  - When full with no pop, the write is dropped: the tag counter does not advance and overflow is set to 1.
  - overflow holds until clr or reset.
- Pointer arithmetic: both pointers are aw bits and wrap naturally; count is aw+1 bits.
- clr:
  - Has priority over capture and pop in the same cycle.
  - Empties storage, zeroes pointers, count, tag counter and overflow.
  - A capture pending in that cycle is discarded.
  - clr does not clear acc_q: an acc in the clr cycle is captured in the following cycle.
- Simultaneous acc pulses in consecutive cycles: each is captured as its own entry, one per cycle.
- Reset mid-transfer: tx_valid drops immediately (asynchronous); the partner must discard the in-flight beat.
- Width rule: sum_local is stored unmodified, with no truncation or sign handling (sums are non-negative).

Test Plan:
- Single capture: acc in cycle 0 with sum_local=24'h000123 in cycle 1 -> in cycle 2, tx_valid=1, tx_data=24'h000123, tx_tag=0, count=1. With tx_ready=0 for 5 cycles, tx_data stays stable. tx_ready=1 for one cycle -> tx_valid=0, count=0.
- Fill and overflow:
  - 16 acc pulses with tx_ready=0 and sums 1..16 -> count=16, full=1, overflow=0.
  - A 17th acc (sum 17) -> dropped: count stays 16, overflow=1.
  - Drain with tx_ready=1 -> data 1..16 with tags 0..15 on consecutive cycles, and overflow stays 1.
- Full with simultaneous push/pop:
  - With count=16, tx_ready=1 in the same cycle a capture of 24'hABCDEF occurs -> count stays 16 and overflow stays 0.
  - 24'hABCDEF appears after the 15 older entries, with tag 0 (wrapped).
- Tag wrap: 20 captures streamed with tx_ready=1 -> tags observed 0..15 then 0..3, with no gaps and no duplicates.
- Flush: 5 entries pending and overflow=1, then clr coincident with an acc_q capture -> next cycle tx_valid=0, count=0, overflow=0, and the captured sum is discarded. A subsequent acc then yields tag 0.
- Async reset: reset driven low mid-cycle while tx_valid=1 and count=3 -> tx_valid=0 and count=0 without waiting for a clock edge. After reset releases, a new capture yields tag 0.
